// File: rtl/uart_pkg.sv
// Shared constants, byte-FSM states and frame layout for the host command link receiver.
package uart_pkg;

    localparam int CLK_HZ_DEF       = 50_000_000;
    localparam int BAUDRATE_DEF     = 115_200;
    localparam int TIMEOUT_BITS_DEF = 20;

    localparam int DIV_DEF  = CLK_HZ_DEF / BAUDRATE_DEF;
    localparam int HALF_DEF = DIV_DEF / 2;

    localparam int FRAME_BYTES = 8;
    localparam int OPCD_BYTES  = 2;
    localparam int ADDR_BYTES  = 2;
    localparam int DATA_BYTES  = 4;

    localparam int OPCD_W  = OPCD_BYTES * 8;
    localparam int ADDR_W  = ADDR_BYTES * 8;
    localparam int DATA_W  = DATA_BYTES * 8;
    localparam int FRAME_W = FRAME_BYTES * 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Field order matches arrival order: byte 0 lands in the MSBs.
    typedef struct packed {
        logic [OPCD_W-1:0] opcode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command-frame output bus: decoded fields plus valid/error pulses, no backpressure.
interface uart_cmd_rx_if;
    import uart_pkg::*;

    logic [OPCD_W-1:0] opcode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              frame_valid;
    logic              frame_err;

    modport master (output opcode, addr, data, frame_valid, frame_err);
    modport slave  (input  opcode, addr, data, frame_valid, frame_err);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserializer behind a 2-FF synchronizer; pulses arrive in the stop-sample cycle.
// No backpressure: each byte is offered for exactly one cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int DIV  = DIV_DEF,
    parameter int HALF = DIV / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       start_det
);

    localparam int CW = $clog2(DIV);

    logic          sync1_q, sync2_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        start_det  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d   = RX_START;
                    start_det = 1'b1;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d      = '0;
                    state_d    = RX_IDLE;
                    byte_valid = sync2_q;
                    byte_err   = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Groups 8 received bytes into opcode/addr/data; frame_valid one cycle after the byte-7 stop sample.
// No backpressure: a missed frame_valid loses the frame; bad or stalled partial frames pulse frame_err.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEF,
    parameter int BAUDRATE     = BAUDRATE_DEF,
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx,
    uart_cmd_rx_if.master frm
);

    localparam int DIV    = calc_div(CLK_HZ, BAUDRATE);
    localparam int HALF   = DIV / 2;
    localparam int TO_CYC = TIMEOUT_BITS * DIV;
    localparam int TW     = $clog2(TO_CYC + 1);

    logic [7:0] byte_data;
    logic       byte_valid, byte_err, start_det;

    uart_rx_byte #(
        .DIV  (DIV),
        .HALF (HALF)
    ) u_rx_byte (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .start_det  (start_det)
    );

    logic [2:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [TW-1:0]      to_q, to_d;
    frame_t             out_q, out_d;
    logic               fv_q, fv_d;
    logic               fe_q, fe_d;
    logic [5:0]         bpos;
    logic               expire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q    <= '0;
            shadow_q <= '0;
            to_q     <= '0;
            out_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            to_q     <= to_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    // Byte n of the frame occupies bits [8*(7-n) +: 8]; 7-n is ~n for a 3-bit index.
    assign bpos   = {~idx_q, 3'b000};
    assign expire = (idx_q != 3'd0) && (to_q == TW'(TO_CYC - 1)) && !start_det;

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        to_d     = to_q;
        out_d    = out_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        if (byte_err) begin
            idx_d = '0;
            to_d  = '0;
            fe_d  = 1'b1;
        end else if (byte_valid) begin
            shadow_d[bpos +: 8] = byte_data;
            to_d                = '0;
            if (idx_q == 3'd7) begin
                out_d = frame_t'(shadow_d);
                fv_d  = 1'b1;
                idx_d = '0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else if (start_det || idx_q == 3'd0) begin
            // Start detection beats a coincident timeout expiry.
            to_d = '0;
        end else if (expire) begin
            idx_d = '0;
            to_d  = '0;
            fe_d  = 1'b1;
        end else begin
            to_d = to_q + TW'(1);
        end
    end

    assign frm.opcode      = out_q.opcode;
    assign frm.addr        = out_q.addr;
    assign frm.data        = out_q.data;
    assign frm.frame_valid = fv_q;
    assign frm.frame_err   = fe_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench: stimulus pushes expected pulses, a monitor pops and compares each DUT pulse.
module tb_uart_cmd_rx;

    localparam int CLK_HZ = 3_200_000;
    localparam int BAUD   = 100_000;
    localparam int TOB    = 20;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int SAMP9  = 2 + HALF + 9 * DIV;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLK_HZ       (CLK_HZ),
        .BAUDRATE     (BAUD),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .frm   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        logic [15:0] op;
        logic [15:0] ad;
        logic [31:0] dt;
        int          tmin;
        int          tmax;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [15:0] m_op  = '0;
    logic [15:0] m_ad  = '0;
    logic [31:0] m_dt  = '0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, required %h", nm, cyc, act, req);
        end
    endtask

    task automatic check_win(input string nm, input int t, input int lo, input int hi);
        n_cmp++;
        if (t < lo || t > hi) begin
            n_bad++;
            $display("FAIL %s: pulse at cycle %0d, required %0d..%0d", nm, t, lo, hi);
        end
    endtask

    // 'at' is the cycle the deciding byte's start bit began; its stop sample lands SAMP9 later.
    task automatic push(input bit is_err, input logic [15:0] op, input logic [15:0] ad,
                        input logic [31:0] dt, input int at);
        exp_t e;
        e.is_err = is_err;
        e.op     = op;
        e.ad     = ad;
        e.dt     = dt;
        e.tmin   = at + SAMP9 - 1;
        e.tmax   = at + SAMP9 + 3;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * DIV) @(negedge clock);
    endtask

    task automatic send_frame(input logic [15:0] op, input logic [15:0] ad, input logic [31:0] dt);
        logic [63:0] f;
        f = {op, ad, dt};
        push(1'b0, op, ad, dt, cyc + 70 * DIV);
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], 1'b1);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        logic [1:0] req_kind;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (!reset) begin
                m_op = '0;
                m_ad = '0;
                m_dt = '0;
                check("reset_state",
                      96'({bus.frame_valid, bus.frame_err, bus.opcode, bus.addr, bus.data}), 96'(0));
            end else if (bus.frame_valid || bus.frame_err) begin
                check("valid_err_overlap", 96'(bus.frame_valid & bus.frame_err), 96'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 96'({bus.frame_valid, bus.frame_err}), 96'(0));
                end else begin
                    e = exp_q.pop_front();
                    req_kind = e.is_err ? 2'b01 : 2'b10;
                    check("pulse_kind", 96'({bus.frame_valid, bus.frame_err}), 96'(req_kind));
                    check_win("pulse_time", cyc, e.tmin, e.tmax);
                    if (!e.is_err) begin
                        m_op = e.op;
                        m_ad = e.ad;
                        m_dt = e.dt;
                    end
                    check("fields", 96'({bus.opcode, bus.addr, bus.data}), 96'({m_op, m_ad, m_dt}));
                end
            end else if (cyc % (4 * DIV) == 0) begin
                check("hold", 96'({bus.opcode, bus.addr, bus.data}), 96'({m_op, m_ad, m_dt}));
            end
        end
    end

    initial begin
        int kb;
        #2 reset = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        idle_bits(2);

        send_frame(16'hFF00, 16'h0000, 32'hBAFEDCBA);
        idle_bits(3);

        for (int i = 0; i < 10; i++)
            send_frame(16'h5A00 + 16'(i), 16'h0100 + 16'(i), 32'hBAFEDCBA + 32'(i));
        idle_bits(3);

        // Bad stop bit on byte 3: partial frame dropped, next frame must not merge.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        push(1'b1, 16'h0, 16'h0, 32'h0, cyc);
        send_byte(8'h44, 1'b0);
        idle_bits(2);
        send_frame(16'h1234, 16'h5678, 32'h9ABCDEF0);
        idle_bits(3);

        // Three bytes then a long idle: timeout 20 bit-times after byte 2 is accepted.
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        kb = cyc;
        send_byte(8'hBE, 1'b1);
        push(1'b1, 16'h0, 16'h0, 32'h0, kb + TOB * DIV);
        idle_bits(25);
        send_frame(16'hCAFE, 16'h0F0F, 32'h01234567);
        idle_bits(3);

        // Short low glitch while idle.
        rx = 1'b0;
        repeat (HALF - 6) @(negedge clock);
        rx = 1'b1;
        idle_bits(2);
        send_frame(16'h7E81, 16'hC33C, 32'h80000001);
        idle_bits(3);

        // Reset in the middle of byte 5.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        idle_bits(3);
        send_frame(16'hFFFF, 16'h8001, 32'hFFFFFFFF);

        for (int i = 0; i < 40 * DIV && exp_q.size() != 0; i++) @(negedge clock);
        idle_bits(2);
        check("pending_expected", 96'(exp_q.size()), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Synthesizable UART receiver and command-frame assembler; the receiving end of the host command link. Deserializes 8N1 bytes from `rx`, groups every 8 bytes into one command frame (2-byte opcode, 2-byte address, 4-byte data) and presents the frame with a one-cycle valid pulse to the controller logic. Malformed bytes and stalled partial frames are discarded and flagged.

## Interface
- `CLK_HZ`, 50000000, system clock frequency
- `BAUDRATE`, 115200, line rate
- `TIMEOUT_BITS`, 20, maximum idle gap in a partial frame, in bit-times
- `clock`  in  1  system clock, 50 MHz nominal
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `rx`  in  1  serial input, asynchronous, idle high
- `opcode`  out  16  opcode of last good frame
- `addr`  out  16  address of last good frame
- `data`  out  32  data of last good frame
- `frame_valid`  out  1  one-cycle pulse, fields updated this cycle
- `frame_err`  out  1  one-cycle pulse, partial frame discarded

## Operation
- DIV = CLK_HZ/BAUDRATE (integer, 434 at defaults); HALF = DIV/2 (217).
- `rx` passes through a 2-FF synchronizer; all logic uses the synchronized value.
- Byte FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: synchronized rx = 0 moves to START, counter cleared.
  - START: after HALF cycles sample; 0 -> DATA, 1 -> IDLE (glitch, no error).
  - DATA: sample every DIV cycles, 8 bits LSB first into shift register.
  - STOP: sample after DIV cycles; 1 -> byte accepted; 0 -> framing error. Either way, return to IDLE in the same cycle, so the next start edge is accepted immediately.
- Frame assembly: 3-bit byte index. Bytes are big-endian in arrival order:
  - bytes 0-1: opcode[15:8], opcode[7:0]
  - bytes 2-3: addr[15:8], addr[7:0]
  - bytes 4-7: data[31:24] … data[7:0]
- Bytes are staged in a 64-bit shadow register. Outputs load from it only on byte 7 acceptance; otherwise they hold.
- Framing error on any byte: index clears to 0, `frame_err` pulses.
- Timeout: while index is 1..7, a counter runs from the last accepted byte. Reaching TIMEOUT_BITS×DIV cycles with no new start detected clears index and pulses `frame_err`. The counter is cleared when a start bit is detected.
- No backpressure; a consumer that misses `frame_valid` loses the frame.

## Timing
- Reset values: `opcode`/`addr`/`data` = 0; `frame_valid`/`frame_err` = 0; FSM IDLE; index 0; synchronizer flops = 1.
- Mid-sample point of bit n (start = 0): 2 + HALF + n×DIV cycles after the rx falling edge, ±1 cycle.
- `frame_valid` is registered: asserted the cycle after the byte-7 stop-bit sample, fields valid the same cycle.
- `frame_err` is registered, one cycle after the failing stop sample or timeout expiry.
- Simultaneous timeout expiry and start detection: start wins, no error.
- `frame_valid` and `frame_err` are never asserted in the same cycle.
- Reset mid-byte or mid-frame aborts immediately, with no pulse on release.
- Back-to-back frames with zero inter-byte gap are sustained indefinitely.

## Structure
- Package `uart_pkg`: CLK_HZ/BAUDRATE defaults, DIV/HALF derivation, frame byte count (8), field widths (OPCD 2, ADDR 2, DATA 4 bytes), byte-FSM state enum.
- Sub-module `uart_rx_byte`: synchronizer plus byte FSM. Outputs `byte_data[7:0]`, `byte_valid` pulse, `byte_err` pulse, `start_det` pulse.
- Top level holds frame index, shadow register, timeout counter and output registers.

## Test plan
- Single frame FF00/0000/BAFEDCBA at 115200 -> one `frame_valid`; opcode 16'hFF00, addr 16'h0000, data 32'hBAFEDCBA; no `frame_err`.
- Ten back-to-back frames, data 32'hBAFEDCBA+i, i = 0..9, zero gap -> ten `frame_valid` pulses in order, data values exact; outputs hold between pulses.
- Stop bit forced 0 on byte 3 of a frame, then a good frame 1234/5678/9ABCDEF0 -> one `frame_err`, then `frame_valid` with exactly those fields; no merged frame.
- 3 bytes sent, then idle 25 bit-times, then a full good frame -> `frame_err` at 20 bit-times after byte 2, then a correct `frame_valid`.
- rx low for 100 cycles (glitch < HALF) during idle -> no byte, no pulses; a following frame is received correctly.
- Reset asserted during byte 5, released, then a full frame -> outputs 0 during reset, no pulses, next frame decoded correctly from byte 0.
